ifu_fetch: RTL and testbench

- Instruction fetch stage for the RV64 single-cycle core; sits directly upstream of the core and supplies its 32-bit instruction word.
- Owns the fetch PC and issues sequential requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small reorder-free queue and hands them, with their PC, to the core via valid/ready.
- Accepts branch/jump redirects from the core (jal/jalr target) and discards stale in-flight responses.

---
 rtl/ifu_fetch.sv | 147 ++++++++++++++
 tb/tb_ifu_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage for the RV64 single-cycle core.
// It owns the fetch PC and issues in-order requests to instruction memory.
// Returned instructions are buffered in a small queue and handed to the core.
// Redirects flush the queue; responses still in flight for the old path are dropped.
// Optional performance counters are enabled with the macro IFU_FETCH_PERF_EN.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IFU_FETCH_PERF_EN
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt,
`endif
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  // Stale responses from several back-to-back redirects can stack up, so drop_cnt gets headroom.
  localparam int unsigned DW = CW + 3;

  logic [63:0]   fetch_pc;
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pend;
  logic [DW-1:0] drop_cnt;
  logic [63:0]   ent_pc   [FIFO_DEPTH];
  logic [31:0]   ent_inst [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled;

  logic req_fire;
  logic pop;
  logic resp_take;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  // Request, output and handshake decode
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && (count < CW'(FIFO_DEPTH));
    imem_req_addr  = {fetch_pc[63:3], 3'b000};
    out_valid      = !rst && !redirect_valid && filled[head_ptr];
    out_inst       = filled[head_ptr] ? ent_inst[head_ptr] : 32'd0;
    out_pc         = filled[head_ptr] ? ent_pc[head_ptr]   : 64'd0;
    req_fire       = imem_req_valid && imem_req_ready;
    pop            = out_valid && out_ready;
    resp_take      = imem_resp_valid && (drop_cnt == DW'(0));
  end

  // Pointer, occupancy, drop and fetch PC state; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= {redirect_pc[63:1], 1'b0};
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
      filled    <= '0;
      drop_cnt  <= drop_cnt + DW'(pend) - DW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + PW'(1);
        fetch_pc  <= fetch_pc + 64'd4;
      end
      if (imem_resp_valid) begin
        if (drop_cnt != DW'(0)) begin
          drop_cnt <= drop_cnt - DW'(1);
        end else begin
          filled[fill_ptr] <= 1'b1;
          fill_ptr         <= fill_ptr + PW'(1);
        end
      end
      if (pop) begin
        filled[head_ptr] <= 1'b0;
        head_ptr         <= head_ptr + PW'(1);
      end
      count <= count + CW'(req_fire) - CW'(pop);
      pend  <= pend + CW'(req_fire) - CW'(resp_take);
    end
  end

  // Queue payload: PC captured at allocation, instruction half selected at fill
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (req_fire) begin
        ent_pc[alloc_ptr] <= fetch_pc;
      end
      if (resp_take) begin
        ent_inst[fill_ptr] <= ent_pc[fill_ptr][2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
      end
    end
  end

  // A response with nothing outstanding and nothing to drop is a memory protocol error
  always_ff @(posedge clk) begin
    if (!rst && imem_resp_valid) begin
      assert ((drop_cnt != DW'(0)) || (pend != CW'(0)));
    end
  end

`ifdef IFU_FETCH_PERF_EN
  // Performance counters: accepted requests, starved consumer cycles, redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (req_fire) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (out_ready && !out_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
      if (redirect_valid) begin
        perf_flush_cnt <= perf_flush_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized bench for ifu_fetch against a queue-based reference model.
// The memory model answers requests in order after a per-request latency.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
`ifdef IFU_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
  logic [63:0] perf_flush_cnt;
`endif

  ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef IFU_FETCH_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model state
  logic [63:0] mq_pc [$];
  int          mq_due [$];
  bit          mq_stale [$];
  logic [63:0] oq [$];
  logic [63:0] exp_req_pc = RST_PC;
  logic [63:0] m_fetch = 0;
  logic [63:0] m_stall = 0;
  logic [63:0] m_flush = 0;
  bit          inited = 0;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h9abc_def0, a[31:0] ^ 32'h1234_5678};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] d;
    d = mem_data({pc[63:3], 3'b000});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model
  task automatic tick(input bit r, input bit redir, input logic [63:0] rpc,
                      input bit rdy, input bit ordy, input int lat);
    bit          resp;
    bit          s;
    bit          e_req_v;
    bit          e_out_v;
    bit          fire;
    bit          popped;
    int          nonstale;
    int          e_count;
    logic [63:0] p;
    @(negedge clk);
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    out_ready      = ordy;
    resp           = !r && (mq_pc.size() > 0) && (mq_due[0] <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_data({mq_pc[0][63:3], 3'b000}) : {$urandom, $urandom};
    #1;
    nonstale = 0;
    foreach (mq_stale[i]) if (!mq_stale[i]) nonstale++;
    e_count = oq.size() + nonstale;
    e_req_v = !r && !redir && (e_count < DEPTH);
    e_out_v = !r && !redir && (oq.size() > 0);
    chk("req_valid", 64'(imem_req_valid), 64'(e_req_v));
    if (e_req_v) chk("req_addr", imem_req_addr, {exp_req_pc[63:3], 3'b000});
    chk("out_valid", 64'(out_valid), 64'(e_out_v));
    if (e_out_v) begin
      chk("out_pc", out_pc, oq[0]);
      chk("out_inst", 64'(out_inst), 64'(exp_inst(oq[0])));
    end else if (!r && inited && e_count == 0) begin
      chk("empty_pc", out_pc, 64'd0);
      chk("empty_inst", 64'(out_inst), 64'd0);
    end
`ifdef IFU_FETCH_PERF_EN
    if (inited) begin
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_stall", perf_stall_cnt, m_stall);
      chk("perf_flush", perf_flush_cnt, m_flush);
    end
`endif
    fire   = e_req_v && rdy;
    popped = e_out_v && ordy;
    if (r) begin
      mq_pc.delete(); mq_due.delete(); mq_stale.delete(); oq.delete();
      exp_req_pc = RST_PC;
      m_fetch = 0; m_stall = 0; m_flush = 0;
      inited = 1;
    end else begin
      if (fire) m_fetch++;
      if (ordy && !e_out_v) m_stall++;
      if (redir) m_flush++;
      if (redir) begin
        if (resp) begin
          void'(mq_pc.pop_front()); void'(mq_due.pop_front()); void'(mq_stale.pop_front());
        end
        foreach (mq_stale[i]) mq_stale[i] = 1'b1;
        oq.delete();
        exp_req_pc = {rpc[63:1], 1'b0};
      end else begin
        s = 1'b1;
        p = '0;
        if (resp) begin
          p = mq_pc.pop_front(); void'(mq_due.pop_front()); s = mq_stale.pop_front();
        end
        if (popped) void'(oq.pop_front());
        if (resp && !s) oq.push_back(p);
        if (fire) begin
          mq_pc.push_back(exp_req_pc);
          mq_due.push_back(cyc + lat);
          mq_stale.push_back(1'b0);
          exp_req_pc = exp_req_pc + 64'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    out_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;

    // Reset
    repeat (3) tick(1, 0, 0, 1, 1, 1);
    // Always-ready memory, 1-cycle response, consumer always ready
    repeat (24) tick(0, 0, 0, 1, 1, 1);
    // Consumer stalls: queue fills to depth, then drains in order
    repeat (10) tick(0, 0, 0, 1, 0, 1);
    repeat (12) tick(0, 0, 0, 1, 1, 1);
    // Latency 3 with requests in flight, then redirect to a halfword-aligned target
    repeat (3) tick(0, 0, 0, 1, 1, 3);
    tick(0, 1, 64'h8000_1002, 1, 1, 3);
    repeat (16) tick(0, 0, 0, 1, 1, 3);
    // Latency 2 then redirect coinciding with a response
    repeat (4) tick(0, 0, 0, 1, 0, 2);
    tick(0, 1, 64'h8000_2004, 1, 1, 2);
    repeat (10) tick(0, 0, 0, 1, 1, 2);
    // Back-to-back redirects
    repeat (3) tick(0, 0, 0, 1, 1, 4);
    tick(0, 1, 64'h8000_3000, 1, 1, 4);
    tick(0, 1, 64'h8000_4003, 1, 1, 4);
    repeat (12) tick(0, 0, 0, 1, 1, 4);
    // Reset mid-operation with filled and in-flight entries
    tick(0, 0, 0, 1, 0, 2);
    tick(0, 0, 0, 1, 0, 2);
    tick(0, 0, 0, 0, 0, 2);
    tick(0, 0, 0, 0, 0, 2);
    tick(1, 0, 0, 1, 1, 2);
    repeat (8) tick(0, 0, 0, 1, 1, 1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(149) == 0),
           ($urandom_range(19) == 0),
           {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffe) | ($urandom & 32'h1)},
           ($urandom_range(3) != 0),
           ($urandom_range(2) != 0),
           int'($urandom_range(4, 1)));
    end
    repeat (10) tick(0, 0, 0, 1, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
